// File: rtl/pipe_scoreboard_if.sv
// Issue-side, pipeline-control and retire signals shared by the core's issue
// stage (master) and the hazard scoreboard (slave).
interface pipe_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int DEPTH = 3
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(DEPTH + 1);

  logic             advance;
  logic [DEPTH:0]   flush_mask;
  logic             iss_valid;
  logic             iss_wen;
  logic [RW-1:0]    iss_wsel;
  logic [SW-1:0]    iss_avail;
  logic [RW-1:0]    rs;
  logic [RW-1:0]    rt;
  logic             stall;
  logic             iss_accept;
  logic [SW-1:0]    fwd_rs;
  logic [SW-1:0]    fwd_rt;
  logic             ret_valid;
  logic [RW-1:0]    ret_wsel;
  logic [SW-1:0]    occupancy;

  modport master (
    output advance, flush_mask, iss_valid, iss_wen, iss_wsel, iss_avail, rs, rt,
    input  stall, iss_accept, fwd_rs, fwd_rt, ret_valid, ret_wsel, occupancy
  );

  modport slave (
    input  advance, flush_mask, iss_valid, iss_wen, iss_wsel, iss_avail, rs, rt,
    output stall, iss_accept, fwd_rs, fwd_rt, ret_valid, ret_wsel, occupancy
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight writers in slots 1..DEPTH and
// derives stall and per-operand forwarding selects for the issuing instruction.
module pipe_scoreboard #(
  parameter int NREGS    = 32,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  pipe_scoreboard_if.slave  sb
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(DEPTH + 1);

  logic [DEPTH:1]  valid_reg;
  logic [RW-1:0]   wsel_reg  [1:DEPTH];
  logic [SW-1:0]   avail_reg [1:DEPTH];
  logic [SW-1:0]   occupancy_reg;

  logic [DEPTH:1]  look_valid;
  logic [DEPTH:1]  kept_valid;
  logic [DEPTH:1]  valid_next;
  logic [SW-1:0]   occupancy_next;
  logic [SW-1:0]   avail_clamped;
  logic            insert;
  logic            haz_rs, haz_rt;
  logic [SW-1:0]   fwd_rs_c, fwd_rt_c;
  logic            stall_c;
  logic            accept_c;

  // Slots being flushed this cycle are already invisible to the lookup.
  assign look_valid = valid_reg & ~sb.flush_mask[DEPTH:1];
  assign kept_valid = look_valid;

  always_comb begin
    avail_clamped = sb.iss_avail;
    if (sb.iss_avail == '0)
      avail_clamped = SW'(1);
    else if (int'(sb.iss_avail) > DEPTH)
      avail_clamped = SW'(DEPTH);
  end

  // Youngest match wins: scan upward and stop at the first hit.
  always_comb begin
    logic found_rs, found_rt;
    found_rs = 1'b0;
    found_rt = 1'b0;
    haz_rs   = 1'b0;
    haz_rt   = 1'b0;
    fwd_rs_c = '0;
    fwd_rt_c = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found_rs && look_valid[k] && wsel_reg[k] == sb.rs) begin
        found_rs = 1'b1;
        if (avail_reg[k] > SW'(k)) haz_rs = 1'b1;
        else                       fwd_rs_c = SW'(k);
      end
      if (!found_rt && look_valid[k] && wsel_reg[k] == sb.rt) begin
        found_rt = 1'b1;
        if (avail_reg[k] > SW'(k)) haz_rt = 1'b1;
        else                       fwd_rt_c = SW'(k);
      end
    end
    if (ZERO_REG != 0 && sb.rs == '0) begin
      haz_rs   = 1'b0;
      fwd_rs_c = '0;
    end
    if (ZERO_REG != 0 && sb.rt == '0) begin
      haz_rt   = 1'b0;
      fwd_rt_c = '0;
    end
  end

  assign stall_c  = sb.iss_valid & (haz_rs | haz_rt);
  assign accept_c = nRST & sb.iss_valid & sb.advance & ~stall_c & ~sb.flush_mask[0];
  assign insert   = accept_c & sb.iss_wen & ~(ZERO_REG != 0 && sb.iss_wsel == '0);

  generate
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_vnext
      if (gi == 1) begin : g_head
        assign valid_next[gi] = insert;
      end else begin : g_body
        assign valid_next[gi] = kept_valid[gi-1];
      end
    end
  endgenerate

  always_comb begin
    occupancy_next = '0;
    for (int k = 1; k <= DEPTH; k++)
      occupancy_next = occupancy_next + SW'(valid_next[k]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_reg     <= '0;
      occupancy_reg <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        wsel_reg[k]  <= '0;
        avail_reg[k] <= '0;
      end
    end else if (sb.advance) begin
      valid_reg     <= valid_next;
      occupancy_reg <= occupancy_next;
      for (int k = DEPTH; k >= 2; k--) begin
        wsel_reg[k]  <= wsel_reg[k-1];
        avail_reg[k] <= avail_reg[k-1];
      end
      wsel_reg[1]  <= insert ? sb.iss_wsel : '0;
      avail_reg[1] <= insert ? avail_clamped : '0;
    end
  end

  assign sb.stall      = stall_c;
  assign sb.iss_accept = accept_c;
  assign sb.fwd_rs     = fwd_rs_c;
  assign sb.fwd_rt     = fwd_rt_c;
  assign sb.ret_valid  = sb.advance & valid_reg[DEPTH] & ~sb.flush_mask[DEPTH];
  assign sb.ret_wsel   = sb.ret_valid ? wsel_reg[DEPTH] : '0;
  assign sb.occupancy  = occupancy_reg;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard (DEPTH=3): forwarding, load-use stall,
// freeze, youngest priority, zero register, flush and async reset.
module tb_pipe_scoreboard;
  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_errors;

  pipe_scoreboard_if #(.NREGS(32), .DEPTH(3)) sb_if ();

  pipe_scoreboard #(.NREGS(32), .DEPTH(3), .ZERO_REG(1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .sb   (sb_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input int wsel, input int avail,
                       input int rs, input int rt, input logic adv, input logic [3:0] flush);
    sb_if.iss_valid  = v;
    sb_if.iss_wen    = wen;
    sb_if.iss_wsel   = 5'(wsel);
    sb_if.iss_avail  = 2'(avail);
    sb_if.rs         = 5'(rs);
    sb_if.rt         = 5'(rt);
    sb_if.advance    = adv;
    sb_if.flush_mask = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 4'b0000);
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 4'b0000);
    tick();
    tick();
    check("rst_stall", int'(sb_if.stall), 0);
    check("rst_fwd_rs", int'(sb_if.fwd_rs), 0);
    check("rst_fwd_rt", int'(sb_if.fwd_rt), 0);
    check("rst_occ", int'(sb_if.occupancy), 0);
    check("rst_ret", int'(sb_if.ret_valid), 0);
    nRST = 1'b1;
    tick();

    // ALU writer r5 walks through all slots, then retires
    drive(1'b1, 1'b1, 5, 1, 0, 0, 1'b1, 4'b0000);
    check("alu_accept", int'(sb_if.iss_accept), 1);
    tick();
    drive(1'b1, 1'b0, 0, 0, 5, 0, 1'b1, 4'b0000);
    check("alu_s1_stall", int'(sb_if.stall), 0);
    check("alu_s1_fwd", int'(sb_if.fwd_rs), 1);
    check("alu_s1_occ", int'(sb_if.occupancy), 1);
    tick();
    drive(1'b1, 1'b0, 0, 0, 5, 0, 1'b1, 4'b0000);
    check("alu_s2_fwd", int'(sb_if.fwd_rs), 2);
    tick();
    drive(1'b1, 1'b0, 0, 0, 5, 0, 1'b1, 4'b0000);
    check("alu_s3_fwd", int'(sb_if.fwd_rs), 3);
    check("alu_ret_valid", int'(sb_if.ret_valid), 1);
    check("alu_ret_wsel", int'(sb_if.ret_wsel), 5);
    tick();
    drive(1'b0, 1'b0, 0, 0, 5, 0, 1'b1, 4'b0000);
    check("alu_drained_occ", int'(sb_if.occupancy), 0);
    check("alu_drained_ret", int'(sb_if.ret_valid), 0);
    check("alu_drained_fwd", int'(sb_if.fwd_rs), 0);

    // load-use on r8 with a two-cycle freeze
    drive(1'b1, 1'b1, 8, 2, 0, 0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, 8, 1'b0, 4'b0000);
    check("ld_stall", int'(sb_if.stall), 1);
    check("ld_accept", int'(sb_if.iss_accept), 0);
    check("ld_fwd_rt", int'(sb_if.fwd_rt), 0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, 8, 1'b0, 4'b0000);
    check("ld_frz_stall", int'(sb_if.stall), 1);
    check("ld_frz_occ", int'(sb_if.occupancy), 1);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, 8, 1'b1, 4'b0000);
    check("ld_adv_stall", int'(sb_if.stall), 1);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, 8, 1'b1, 4'b0000);
    check("ld_go_stall", int'(sb_if.stall), 0);
    check("ld_go_fwd_rt", int'(sb_if.fwd_rt), 2);
    check("ld_go_accept", int'(sb_if.iss_accept), 1);
    tick();
    idle(3);

    // two back-to-back writers of r3: youngest must win
    drive(1'b1, 1'b1, 3, 1, 0, 0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 3, 0, 0, 0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 0, 0, 3, 3, 1'b1, 4'b0000);
    check("young_fwd_rs", int'(sb_if.fwd_rs), 1);
    check("young_fwd_rt", int'(sb_if.fwd_rt), 1);
    check("young_occ", int'(sb_if.occupancy), 2);
    tick();
    idle(3);

    // writes to r0 are never tracked
    drive(1'b1, 1'b1, 0, 1, 0, 0, 1'b1, 4'b0000);
    check("zero_accept", int'(sb_if.iss_accept), 1);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 4'b0000);
    check("zero_occ", int'(sb_if.occupancy), 0);
    check("zero_fwd_rs", int'(sb_if.fwd_rs), 0);
    check("zero_stall", int'(sb_if.stall), 0);
    tick();

    // flush slot 1 and the issuing instruction
    drive(1'b1, 1'b1, 6, 1, 0, 0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 4, 1, 0, 0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 9, 1, 0, 0, 1'b1, 4'b0011);
    check("fl_accept", int'(sb_if.iss_accept), 0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 4, 6, 1'b1, 4'b0000);
    check("fl_fwd_rs", int'(sb_if.fwd_rs), 0);
    check("fl_fwd_rt", int'(sb_if.fwd_rt), 3);
    check("fl_occ", int'(sb_if.occupancy), 1);
    drive(1'b1, 1'b0, 0, 0, 4, 6, 1'b1, 4'b1000);
    check("fl_ret_killed", int'(sb_if.ret_valid), 0);
    check("fl_fwd_rt_killed", int'(sb_if.fwd_rt), 0);
    tick();
    idle(2);

    // async reset drops an in-flight load with no retire pulse
    drive(1'b1, 1'b1, 7, 2, 0, 0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 0, 0, 7, 0, 1'b1, 4'b0000);
    check("ar_pre_stall", int'(sb_if.stall), 1);
    #2 nRST = 1'b0;
    #1;
    check("ar_occ", int'(sb_if.occupancy), 0);
    check("ar_stall", int'(sb_if.stall), 0);
    check("ar_accept", int'(sb_if.iss_accept), 0);
    check("ar_ret", int'(sb_if.ret_valid), 0);
    nRST = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
Parametrised register-hazard scoreboard for the in-order pipelined core. It replaces the fixed forwarding/load-use logic with one block that supports a configurable pipeline depth and a per-instruction result latency. It sits beside the issue (ID->EX) point. It tracks in-flight register writes and produces the stall and per-operand forwarding selects. It supports stage-selective flush and whole-pipe freeze.

Parameters:
NREGS, 32, number of architectural registers; RW = $clog2(NREGS).
DEPTH, 3, number of tracked in-flight slots (EX..WB); SW = $clog2(DEPTH+1).
ZERO_REG, 1, when 1, register 0 is hardwired and never creates a hazard.

Ports:
CLK  in  1  clock.
nRST  in  1  asynchronous active-low reset.
advance  in  1  pipeline enable; 0 freezes all slots (cache miss, etc.).
flush_mask  in  DEPTH+1  bit0 kills the issuing instruction; bit k kills slot k (k=1..DEPTH).
iss_valid  in  1  an instruction is presented for issue.
iss_wen  in  1  the instruction writes a register.
iss_wsel  in  RW  destination register.
iss_avail  in  SW  slot index at which its result becomes forwardable (1 = ALU, 2 = load).
rs  in  RW  source operand 1 of the issuing instruction.
rt  in  RW  source operand 2 of the issuing instruction.
stall  out  1  the issuing instruction must be held.
iss_accept  out  1  the instruction is inserted this cycle.
fwd_rs  out  SW  0 = register file; k = forward from slot k.
fwd_rt  out  SW  same encoding as fwd_rs, for rt.
ret_valid  out  1  the slot-DEPTH entry retires this cycle.
ret_wsel  out  RW  the retiring destination register.
occupancy  out  SW  count of valid slots.

Behaviour:
- Storage: DEPTH slots, each holding {valid, wsel, avail}. A slot is valid only for accepted writers; with ZERO_REG=1, an instruction with wsel=0 is never inserted.
- Reset (async, nRST=0): all slots invalid. stall=0, iss_accept=0, fwd_rs=fwd_rt=0, ret_valid=0, ret_wsel=0, occupancy=0. Reset mid-operation drops all in-flight entries with no retire pulse.
- Lookup (combinational, current slot contents, post-flush_mask view):
  - Per operand, find the lowest-index (youngest) valid slot k whose wsel matches.
  - No match, or operand = 0 with ZERO_REG=1 -> fwd = 0, no hazard.
  - Match with avail <= k -> fwd = k.
  - Match with avail > k -> hazard, fwd = 0.
- stall = iss_valid & (hazard on rs | hazard on rt). rs = rt is evaluated identically.
- iss_accept = iss_valid & advance & ~stall & ~flush_mask[0].
- Sequential update on the CLK rising edge, only when advance=1:
  - Slots flagged in flush_mask[DEPTH:1] are invalidated first.
  - All slots then shift k -> k+1.
  - Slot 1 loads the issuing entry if iss_accept & iss_wen (and ZERO_REG allows it); otherwise slot 1 loads a bubble.
  - The entry leaving slot DEPTH is discarded; the register file holds its value thereafter.
- advance=0: no shift, no insert, no flush, no aging. Outputs are recomputed each cycle and stall persists.
- ret_valid = advance & slot[DEPTH].valid & ~flush_mask[DEPTH]; ret_wsel = slot[DEPTH].wsel, or 0 when ret_valid=0.
- iss_avail = 0 is treated as 1; iss_avail > DEPTH is clamped to DEPTH. The stored avail is the clamped value.
- occupancy: popcount of valid slots, registered, updated on the same edge as the slots.
- Latency: an inserted entry is visible to lookup in the cycle after acceptance, at slot 1.

Test Plan:
- Reset, DEPTH=3 -> stall=0, fwd_rs=fwd_rt=0, occupancy=0, ret_valid=0.
- Issue wsel=5, avail=1, advance=1; next cycle rs=5 -> stall=0, fwd_rs=1, occupancy=1. Third cycle rs=5 -> fwd_rs=2. Fourth cycle -> fwd_rs=3. On the next advance -> ret_valid=1, ret_wsel=5.
- Load-use: issue wsel=8, avail=2; next cycle rt=8 -> stall=1, iss_accept=0, fwd_rt=0. Hold advance=0 for 2 cycles -> stall stays 1. Advance once -> stall=0, fwd_rt=2.
- Youngest priority: issue wsel=3 twice back-to-back (avail=1); consumer rs=3 -> fwd_rs=1, not 2.
- Zero register: issue wsel=0, wen=1 -> occupancy unchanged. Consumer rs=0 -> fwd_rs=0, stall=0.
- Flush: slots 1 and 2 hold wsel=4 and wsel=6. flush_mask=4'b0011 with iss_valid=1 -> iss_accept=0. Next cycle rs=4 -> fwd_rs=0; rt=6 -> fwd_rt=3; occupancy=1.
